// File: rtl/csi_pkg.sv
// Shared CSI-2 receive-path constants and helpers.
package csi_pkg;

  localparam int RAW10_UNIT_BYTES = 5;
  localparam int PIX_PER_OUT      = 8;
  localparam int OUT_WIDTH        = 128;
  localparam int GROUP_BYTES      = 2 * RAW10_UNIT_BYTES;
  localparam int HOLD_BYTES       = 12;

  // Word position inside the 5-word / 2-output-group cycle.
  typedef enum logic [2:0] {
    PH0 = 3'd0,
    PH1 = 3'd1,
    PH2 = 3'd2,
    PH3 = 3'd3,
    PH4 = 3'd4
  } phase_e;

  // Place a 10-bit pixel into its 16-bit output slot.
  function automatic logic [15:0] pix_slot(input logic [9:0] pix, input bit msb_align);
    pix_slot = msb_align ? {pix, 6'b0} : {6'b0, pix};
  endfunction

endpackage

// File: rtl/raw10_group_unpack.sv
// Combinational unpack of two RAW10 units (10 bytes) into eight 16-bit pixel slots.
// Byte 0 is bytes_i[7:0]; the first pixel lands in data_o[127:112].
module raw10_group_unpack
  import csi_pkg::*;
#(
  parameter bit OUT_MSB_ALIGN = 1'b1
) (
  input  logic [8*GROUP_BYTES-1:0] bytes_i,
  output logic [OUT_WIDTH-1:0]     data_o
);

  // Pixel Pk of unit u = {Bk, B4[2k+1:2k]}.
  always_comb begin
    data_o = '0;
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 4; k++) begin
        data_o[OUT_WIDTH-1-16*(4*u+k) -: 16] =
          pix_slot({bytes_i[8*(RAW10_UNIT_BYTES*u+k) +: 8],
                    bytes_i[8*(RAW10_UNIT_BYTES*u+4)+2*k +: 2]}, OUT_MSB_ALIGN);
      end
    end
  end

endmodule

// File: rtl/raw10_depacker.sv
// RAW10 byte-stream depacker: 4 bytes/cycle in, 8 unpacked pixels out per group,
// with line qualifiers, per-line pixel count and partial-line detection.
module raw10_depacker
  import csi_pkg::*;
#(
  parameter bit OUT_MSB_ALIGN = 1'b1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 line_valid_i,
  input  logic                 data_valid_i,
  input  logic [31:0]          data_i,
  output logic [OUT_WIDTH-1:0] data_o,
  output logic                 data_valid_o,
  output logic                 line_valid_o,
  output logic [15:0]          line_pixels_o,
  output logic                 partial_err_o
);

  phase_e                  phase_q, phase_d;
  logic [8*HOLD_BYTES-1:0] buf_q, buf_d;
  logic [OUT_WIDTH-1:0]    data_q, data_d;
  logic                    dv_q, dv_d;
  logic                    lv_q;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             lpix_q, lpix_d;
  logic                    perr_q, perr_d;

  logic                    accept;
  logic                    line_end;
  logic [6:0]              shamt;
  logic [8*HOLD_BYTES-1:0] merged;
  logic [OUT_WIDTH-1:0]    unpacked;

  assign accept   = line_valid_i & data_valid_i;
  assign line_end = lv_q & ~line_valid_i;

  // Bytes above the current fill level are always zero, so the new word can be ORed in.
  always_comb begin
    shamt = 7'd0;
    case (phase_q)
      PH0:     shamt = 7'd0;
      PH1:     shamt = 7'd32;
      PH2:     shamt = 7'd64;
      PH3:     shamt = 7'd16;
      PH4:     shamt = 7'd48;
      default: shamt = 7'd0;
    endcase
    merged = buf_q | ({64'b0, data_i} << shamt);
  end

  raw10_group_unpack #(
    .OUT_MSB_ALIGN(OUT_MSB_ALIGN)
  ) u_unpack (
    .bytes_i(merged[8*GROUP_BYTES-1:0]),
    .data_o (unpacked)
  );

  // Next-state: phase advance, buffer append/drain, group emit, line-end bookkeeping.
  always_comb begin
    phase_d = phase_q;
    buf_d   = buf_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    cnt_d   = cnt_q;
    lpix_d  = lpix_q;
    perr_d  = 1'b0;
    if (line_end) begin
      phase_d = PH0;
      buf_d   = '0;
      lpix_d  = cnt_q;
      cnt_d   = '0;
      perr_d  = (phase_q != PH0);
    end else if (accept) begin
      case (phase_q)
        PH0:     phase_d = PH1;
        PH1:     phase_d = PH2;
        PH2:     phase_d = PH3;
        PH3:     phase_d = PH4;
        PH4:     phase_d = PH0;
        default: phase_d = PH0;
      endcase
      buf_d = merged;
      if (phase_q == PH2 || phase_q == PH4) begin
        dv_d   = 1'b1;
        data_d = unpacked;
        cnt_d  = (cnt_q > 16'hFFF7) ? 16'hFFFF : cnt_q + 16'd8;
        // After PH2 two bytes of the new word carry over; after PH4 nothing does.
        buf_d  = (phase_q == PH2) ? {80'b0, merged[95:80]} : '0;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q <= PH0;
      buf_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      lv_q    <= 1'b0;
      cnt_q   <= '0;
      lpix_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      buf_q   <= buf_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      lv_q    <= line_valid_i;
      cnt_q   <= cnt_d;
      lpix_q  <= lpix_d;
      perr_q  <= perr_d;
    end
  end

  assign data_o        = data_q;
  assign data_valid_o  = dv_q;
  assign line_valid_o  = lv_q;
  assign line_pixels_o = lpix_q;
  assign partial_err_o = perr_q;

endmodule

// File: tb/tb_raw10_depacker.sv
// Bench for raw10_depacker: lines are generated as pixel lists, packed to RAW10
// bytes, driven in, and every output word is compared with the original pixels.
module tb_raw10_depacker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_i, line_valid_i, data_valid_i;
  logic [31:0]  data_i;
  logic [127:0] data_m, data_l;
  logic         dv_m, dv_l, lvo_m, lvo_l, pe_m, pe_l;
  logic [15:0]  lp_m, lp_l;

  raw10_depacker #(.OUT_MSB_ALIGN(1'b1)) dut_m (
    .clk_i(clk), .reset_i(reset_i), .line_valid_i(line_valid_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_o(data_m),
    .data_valid_o(dv_m), .line_valid_o(lvo_m), .line_pixels_o(lp_m),
    .partial_err_o(pe_m));

  raw10_depacker #(.OUT_MSB_ALIGN(1'b0)) dut_l (
    .clk_i(clk), .reset_i(reset_i), .line_valid_i(line_valid_i),
    .data_valid_i(data_valid_i), .data_i(data_i), .data_o(data_l),
    .data_valid_o(dv_l), .line_valid_o(lvo_l), .line_pixels_o(lp_l),
    .partial_err_o(pe_l));

  int checks = 0;
  int failures = 0;

  logic [9:0]   pix[$];
  logic [7:0]   byt[$];
  logic [9:0]   pat[4];
  int           acc_bytes, emitted;
  logic         prev_lv;
  logic [15:0]  exp_lpix;
  int           seen_words, pe_seen;
  logic [127:0] first_m, first_l;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected output word k of the current line, straight from the pixel list.
  function automatic logic [127:0] exp_word(input int k, input bit msb);
    logic [127:0] w;
    w = '0;
    for (int j = 0; j < 8; j++)
      w[127-16*j -: 16] = msb ? {pix[8*k+j], 6'b0} : {6'b0, pix[8*k+j]};
    return w;
  endfunction

  // mode 0: incrementing, 1: random, 2: fixed LSB pattern.
  task automatic build_line(input int npix, input int mode);
    pix.delete();
    byt.delete();
    for (int i = 0; i < npix; i++) begin
      case (mode)
        0:       pix.push_back(10'(i));
        1:       pix.push_back(10'($urandom));
        default: pix.push_back(pat[i%4]);
      endcase
    end
    for (int u = 0; u < npix/4; u++) begin
      for (int k = 0; k < 4; k++) byt.push_back(pix[4*u+k][9:2]);
      byt.push_back({pix[4*u+3][1:0], pix[4*u+2][1:0], pix[4*u+1][1:0], pix[4*u][1:0]});
    end
  endtask

  task automatic step(input logic lv, input logic dv);
    int   w, k;
    logic exp_valid, exp_perr;
    exp_valid = 1'b0;
    exp_perr  = 1'b0;
    k = 0;
    line_valid_i = lv;
    data_valid_i = dv;
    if (lv && dv) begin
      w = acc_bytes / 4;
      data_i = {byt[4*w+3], byt[4*w+2], byt[4*w+1], byt[4*w]};
      acc_bytes += 4;
      if (acc_bytes / 10 > emitted) begin
        exp_valid = 1'b1;
        k = emitted;
        emitted++;
      end
    end else begin
      data_i = $urandom;
    end
    if (prev_lv && !lv) begin
      exp_perr  = (acc_bytes % 20) != 0;
      exp_lpix  = (emitted * 8 > 65535) ? 16'hFFFF : 16'(emitted * 8);
      acc_bytes = 0;
      emitted   = 0;
    end
    prev_lv = lv;
    @(posedge clk);
    #1;
    check("dv_m", dv_m, exp_valid);
    check("dv_l", dv_l, exp_valid);
    if (exp_valid) begin
      check("data_m", data_m, exp_word(k, 1'b1));
      check("data_l", data_l, exp_word(k, 1'b0));
    end
    check("lvo_m", lvo_m, lv);
    check("lvo_l", lvo_l, lv);
    check("perr_m", pe_m, exp_perr);
    check("perr_l", pe_l, exp_perr);
    check("lpix_m", lp_m, exp_lpix);
    check("lpix_l", lp_l, exp_lpix);
    if (dv_m) begin
      if (seen_words == 0) begin
        first_m = data_m;
        first_l = data_l;
      end
      seen_words++;
    end
    if (pe_m) pe_seen++;
  endtask

  // stall 0: continuous, 1: every 3rd cycle idle, 2: random idles.
  task automatic run_line(input int npix, input int mode, input int nwords,
                          input int stall, input int gap);
    int   sent, cyc;
    logic dv;
    build_line(npix, mode);
    seen_words = 0;
    pe_seen    = 0;
    sent = 0;
    cyc  = 0;
    while (sent < nwords) begin
      case (stall)
        0:       dv = 1'b1;
        1:       dv = (cyc % 3) != 2;
        default: dv = $urandom_range(0, 3) != 0;
      endcase
      step(1'b1, dv);
      if (dv) sent++;
      cyc++;
      if (cyc > 10 * nwords + 20) begin
        failures++;
        $display("FAIL stall_bound observed=%0d cycles required<=%0d", cyc, 10*nwords+20);
        break;
      end
    end
    for (int g = 0; g < gap; g++) step(1'b0, 1'($urandom_range(0, 1)));
  endtask

  initial begin
    pat[0] = 10'h3FC; pat[1] = 10'h001; pat[2] = 10'h2AA; pat[3] = 10'h157;
    acc_bytes = 0; emitted = 0; prev_lv = 1'b0; exp_lpix = '0;
    seen_words = 0; pe_seen = 0; first_m = '0; first_l = '0;
    reset_i = 1'b1; line_valid_i = 1'b0; data_valid_i = 1'b0; data_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", data_m, 128'h0);
    check("rst_dv", dv_m, 1'b0);
    check("rst_lpix", lp_m, 16'h0);
    check("rst_perr", pe_m, 1'b0);
    reset_i = 1'b0;
    step(1'b0, 1'b0);

    // 768 incrementing pixels, continuous.
    run_line(768, 0, 240, 0, 2);
    check("l1_words", seen_words, 96);
    check("l1_first", first_m, 128'h0000_0040_0080_00C0_0100_0140_0180_01C0);
    check("l1_lpix", lp_m, 16'd768);
    check("l1_perr", pe_seen, 0);

    // Same line with every 3rd cycle idle.
    run_line(768, 0, 240, 1, 2);
    check("l2_words", seen_words, 96);
    check("l2_lpix", lp_m, 16'd768);

    // LSB extraction pattern.
    run_line(64, 2, 20, 0, 2);
    check("lsb_first_l", first_l, 128'h03FC_0001_02AA_0157_03FC_0001_02AA_0157);
    check("lsb_first_m", first_m, 128'hFF00_0040_AA80_55C0_FF00_0040_AA80_55C0);

    // 12-word line: ends at phase 2.
    run_line(48, 1, 12, 0, 2);
    check("short_words", seen_words, 4);
    check("short_lpix", lp_m, 16'd32);
    check("short_perr", pe_seen, 1);
    run_line(768, 1, 240, 2, 2);
    check("after_short_words", seen_words, 96);

    // Reset at phase 3 mid-line.
    build_line(768, 1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1);
    reset_i = 1'b1; line_valid_i = 1'b0; data_valid_i = 1'b0;
    #1;
    check("arst_lvo", lvo_m, 1'b0);
    check("arst_lpix", lp_m, 16'h0);
    check("arst_data", data_m, 128'h0);
    check("arst_dv", dv_m, 1'b0);
    @(posedge clk);
    #1;
    check("arst_hold_lvo", lvo_m, 1'b0);
    reset_i = 1'b0;
    acc_bytes = 0; emitted = 0; prev_lv = 1'b0; exp_lpix = '0;
    step(1'b0, 1'b0);
    run_line(768, 0, 240, 2, 2);
    check("post_rst_words", seen_words, 96);
    check("post_rst_lpix", lp_m, 16'd768);

    // Back-to-back lines with a one-cycle gap.
    for (int r = 0; r < 2; r++) begin
      run_line(768, 1, 240, 0, 1);
      check("b2b_words", seen_words, 96);
    end
    step(1'b0, 1'b0);

    // Random-length lines with random stalls.
    for (int r = 0; r < 4; r++) run_line(128, 1, $urandom_range(1, 40), 2, $urandom_range(1, 3));
    step(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
